// File: rtl/mcoi_rx_link_guard_pkg.sv
// MCPkg: shared constants and types for the MCOI RX link guard.
// Provides GEFE_INTERLOCK, the guard FSM state enum, and the clock/reset bundle type.
package MCPkg;
  localparam logic [31:0] GEFE_INTERLOCK = 32'hCAFE_0D0D;
  typedef enum logic [1:0] {SAFE = 2'd0, ARMING = 2'd1, ARMED = 2'd2, FAULT = 2'd3} rxguard_state_t;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/mcoi_rx_link_guard_if.sv
// mcoi_rx_link_guard_if: received GBT frame fields in, guarded motor/memory words out.
// Ports (slave = guard side): rx_ready_i, rx_clken_i, interlock_ib32, motor_data_ib64,
// mem_data_ib16 in; motorControl_ob64, mem_data_ob16, mem_valid_o, armed_o,
// state_ob2, fault_cnt_ob16 out.
interface mcoi_rx_link_guard_if;
  logic        rx_ready_i;
  logic        rx_clken_i;
  logic [31:0] interlock_ib32;
  logic [63:0] motor_data_ib64;
  logic [15:0] mem_data_ib16;
  logic [63:0] motorControl_ob64;
  logic [15:0] mem_data_ob16;
  logic        mem_valid_o;
  logic        armed_o;
  logic [1:0]  state_ob2;
  logic [15:0] fault_cnt_ob16;
  modport slave (
    input  rx_ready_i, rx_clken_i, interlock_ib32, motor_data_ib64, mem_data_ib16,
    output motorControl_ob64, mem_data_ob16, mem_valid_o, armed_o, state_ob2, fault_cnt_ob16
  );
  modport master (
    output rx_ready_i, rx_clken_i, interlock_ib32, motor_data_ib64, mem_data_ib16,
    input  motorControl_ob64, mem_data_ob16, mem_valid_o, armed_o, state_ob2, fault_cnt_ob16
  );
endinterface

// File: rtl/mcoi_rx_link_guard_link_watchdog.sv
// link_watchdog: counts cycles without a frame strobe and pulses timeout at g_timeout-1.
// Ports: clk, rst_n (async, active low), clear_i (frame strobe), enable_i (guard armed),
// timeout_o (combinational pulse, only while enabled and not cleared).
module link_watchdog #(
  parameter int g_timeout = 400
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);
  localparam int W = $clog2(g_timeout) + 1;
  localparam logic [W-1:0] LAST = W'(g_timeout - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (!enable_i || clear_i) ? '0 : (cnt_q == LAST) ? cnt_q : cnt_q + W'(1);
    timeout_o = enable_i && !clear_i && (cnt_q == LAST);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mcoi_rx_link_guard.sv
// mcoi_rx_link_guard: passes received motor/memory data only after a stable, verified link.
// Ports: ClkRs_ix (clk + async active-low reset), rx_if (slave modport of mcoi_rx_link_guard_if).
module mcoi_rx_link_guard
  import MCPkg::*;
#(
  parameter int g_arm_frames = 16,
  parameter int g_timeout    = 400,
  parameter int g_holdoff    = 4000
) (
  input ckrs_t ClkRs_ix,
  mcoi_rx_link_guard_if.slave rx_if
);
  localparam int AW = $clog2(g_arm_frames) + 1;
  localparam int HW = $clog2(g_holdoff) + 1;
  localparam logic [AW-1:0] ARM_LAST  = AW'(g_arm_frames - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(g_holdoff - 1);
  logic clk, rst_n;
  assign clk   = ClkRs_ix.clk;
  assign rst_n = ClkRs_ix.reset;
  logic il_ok, loss, good, latch, timeout;
  rxguard_state_t state_q, state_d;
  logic [AW-1:0] arm_cnt_q, arm_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [63:0] motor_q, motor_d;
  logic [15:0] mem_q, mem_d;
  logic valid_q, valid_d;
  logic [15:0] fault_cnt_q, fault_cnt_d;
  assign il_ok = rx_if.interlock_ib32 == GEFE_INTERLOCK;
  assign loss  = !rx_if.rx_ready_i || !il_ok;
  assign good  = rx_if.rx_clken_i && !loss;
  assign latch = (state_q == ARMED) && good;
  link_watchdog #(.g_timeout(g_timeout)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (rx_if.rx_clken_i),
    .enable_i (state_q == ARMED),
    .timeout_o(timeout)
  );
  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    hold_cnt_d = '0;
    case (state_q)
      SAFE:
        if (!loss) begin
          state_d   = ARMING;
          arm_cnt_d = '0;
        end
      ARMING:
        if (loss) begin
          state_d   = SAFE;
          arm_cnt_d = '0;
        end else if (good) begin
          arm_cnt_d = arm_cnt_q + AW'(1);
          if (arm_cnt_q == ARM_LAST) state_d = ARMED;
        end
      ARMED:
        if (loss || timeout) state_d = FAULT;
      FAULT:
        if (hold_cnt_q == HOLD_LAST) state_d = SAFE;
        else hold_cnt_d = hold_cnt_q + HW'(1);
    endcase
    // Outputs follow the next state so that leaving ARMED deactivates motors on the same edge.
    motor_d     = (state_d != ARMED) ? '1 : latch ? rx_if.motor_data_ib64 : motor_q;
    mem_d       = latch ? rx_if.mem_data_ib16 : mem_q;
    valid_d     = latch;
    fault_cnt_d = (state_d == FAULT && state_q != FAULT) ? sat_inc16(fault_cnt_q) : fault_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= SAFE;
      arm_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      motor_q     <= '1;
      mem_q       <= '0;
      valid_q     <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      arm_cnt_q   <= arm_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      motor_q     <= motor_d;
      mem_q       <= mem_d;
      valid_q     <= valid_d;
      fault_cnt_q <= fault_cnt_d;
    end
  assign rx_if.motorControl_ob64 = motor_q;
  assign rx_if.mem_data_ob16     = mem_q;
  assign rx_if.mem_valid_o       = valid_q;
  assign rx_if.armed_o           = state_q == ARMED;
  assign rx_if.state_ob2         = state_q;
  assign rx_if.fault_cnt_ob16    = fault_cnt_q;
endmodule

// File: doc/mcoi_rx_link_guard.md
MCOI_RX_LINK_GUARD -- requirements
Module: mcoi_rx_link_guard

Interface
REQ-001 The block SHALL have parameter g_arm_frames, default 16, meaning consecutive good frames required before motor data is passed.
REQ-002 The block SHALL have parameter g_timeout, default 400, meaning clock cycles without rx_clken_i before a link fault is declared.
REQ-003 The block SHALL have parameter g_holdoff, default 4000, meaning clock cycles spent in FAULT before returning to SAFE.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; the ports are listed below.
REQ-005 ClkRs_ix.clk  input  1  clock; GBT RX frame clock.
REQ-006 ClkRs_ix.reset  input  1  asynchronous, active-low reset.
REQ-007 rx_ready_i  input  1  GBT RX link ready.
REQ-008 rx_clken_i  input  1  received-frame strobe.
REQ-009 interlock_ib32  input  32  serial feedback loop word.
REQ-010 motor_data_ib64  input  64  received motor control field.
REQ-011 mem_data_ib16  input  16  received memory field.
REQ-012 motorControl_ob64  output  64  guarded motor control word.
REQ-013 mem_data_ob16  output  16  guarded memory word.
REQ-014 mem_valid_o  output  1  one-cycle strobe that qualifies mem_data_ob16.
REQ-015 armed_o  output  1  high only in state ARMED.
REQ-016 state_ob2  output  2  current FSM state.
REQ-017 fault_cnt_ob16  output  16  saturating count of FAULT entries.

Function
REQ-018 A good frame SHALL be a cycle in which rx_clken_i=1, rx_ready_i=1 and interlock_ib32==GEFE_INTERLOCK.
REQ-019 A loss event SHALL be a cycle in which rx_ready_i=0, or interlock_ib32!=GEFE_INTERLOCK.
REQ-020 The FSM SHALL have four states, encoded SAFE=0, ARMING=1, ARMED=2, FAULT=3.
REQ-021 In SAFE, the absence of a loss event SHALL move the FSM to ARMING and clear the arm counter.
REQ-022 In ARMING, each good frame SHALL increment the arm counter.
REQ-023 In ARMING, the good frame that brings the count to g_arm_frames SHALL move the FSM to ARMED on the next clock.
REQ-024 In ARMING, a loss event SHALL move the FSM to SAFE (not FAULT) and clear the arm counter.
REQ-025 In ARMED, each good frame SHALL register motor_data_ib64 into motorControl_ob64, and mem_data_ib16 into mem_data_ob16.
REQ-026 In ARMED, each good frame SHALL pulse mem_valid_o for one cycle, with 1-cycle latency.
REQ-027 Between good frames, motorControl_ob64 and mem_data_ob16 SHALL hold their last values.
REQ-028 In ARMED, a watchdog counter SHALL reset to 0 on every rx_clken_i and increment otherwise.
REQ-029 When the watchdog reaches g_timeout-1 without a strobe, the FSM SHALL go to FAULT.
REQ-030 In ARMED, a loss event SHALL move the FSM to FAULT on the next clock.
REQ-031 A loss event and rx_clken_i in the same cycle SHALL count as a loss: no data is latched and mem_valid_o stays 0.
REQ-032 In every state other than ARMED, motorControl_ob64 SHALL be all ones (all motors deactivated), registered.
REQ-033 In every state other than ARMED, mem_valid_o SHALL be 0.
REQ-034 On entry to FAULT, fault_cnt_ob16 SHALL increment, saturating at 16'hFFFF.
REQ-035 On entry to FAULT, the holdoff counter SHALL load 0.
REQ-036 The FSM SHALL leave FAULT for SAFE after exactly g_holdoff cycles, regardless of link state.
REQ-037 All counters SHALL be sized to $clog2 of their parameter +1 and SHALL NOT wrap.

Reset
REQ-038 While reset is asserted, state SHALL be SAFE and motorControl_ob64 SHALL be all ones.
REQ-039 While reset is asserted, mem_data_ob16, mem_valid_o, armed_o, fault_cnt_ob16 and all internal counters SHALL be 0.
REQ-040 Reset asserted mid-operation SHALL force the safe outputs asynchronously, without waiting for a clock edge.

Structure
REQ-041 GEFE_INTERLOCK and the state enum type rxguard_state_t SHALL live in the shared MCPkg package.
REQ-042 A single sub-module, link_watchdog, SHALL be used; it has a clear input, enable input, and timeout pulse output.

Verification
REQ-043 Reset, then 16 good frames -> state goes 0->1->2; motorControl_ob64 = '1 until the first good frame in ARMED; frame data 64'h0123_4567_89AB_CDEF appears 1 cycle after its strobe.
REQ-044 In ARMING at 15 good frames, interlock_ib32 = 32'h0 -> SAFE, arm counter 0; rearming needs a full 16 frames.
REQ-045 ARMED, rx_clken_i stopped -> FAULT exactly 400 cycles after the last strobe; outputs = '1 next cycle; fault_cnt_ob16 = 1; SAFE after 4000 cycles.
REQ-046 ARMED, rx_ready_i low in the same cycle as rx_clken_i -> no data latch, mem_valid_o = 0, FAULT next cycle.
REQ-047 fault_cnt_ob16 forced to 16'hFFFF plus one more fault -> stays 16'hFFFF.
REQ-048 Reset asserted asynchronously mid-ARMED -> motorControl_ob64 = '1 before the next clock edge; state_ob2 = 0.
